bldc_pwm_bank: RTL and testbench

Multi-phase, parametrised PWM generator for the BLDC gate drivers, succeeding the single-phase driver. One shared period counter drives NUM_PHASES complementary high/low gate pairs. Each phase has:

- true dead time on both switching edges;
- double-buffered duty cycle and high-Z, applied only at period boundaries;
- selectable edge- or center-aligned carrier.

It sits between the motor commutation/control logic and the FPGA gate-drive pins.

---
 rtl/bldc_pwm_bank.sv | 122 ++++++++++++
 tb/tb_bldc_pwm_bank.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_pwm_bank.sv
// Multi-phase complementary PWM bank for BLDC gate drivers: a shared carrier counter,
// double-buffered duty/high-Z per phase and dead-time insertion on every drive change.
module bldc_pwm_bank #(
    parameter int unsigned NUM_PHASES     = 3,
    parameter int unsigned DUTY_WIDTH     = 10,
    parameter int unsigned DEAD_TIME      = 2,
    parameter int unsigned CENTER_ALIGNED = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PHASES*DUTY_WIDTH-1:0] duty_cycle,
    input  logic [NUM_PHASES-1:0]            high_z,
    input  logic                             load,
    output logic [NUM_PHASES-1:0]            pwm_high,
    output logic [NUM_PHASES-1:0]            pwm_low,
    output logic                             period_start
);

    localparam int unsigned           DT_W      = 8;
    localparam logic [DUTY_WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [DT_W-1:0]       DT        = DT_W'(DEAD_TIME);

    localparam logic [1:0] TGT_OFF  = 2'd0;
    localparam logic [1:0] TGT_HIGH = 2'd1;
    localparam logic [1:0] TGT_LOW  = 2'd2;

    logic [DUTY_WIDTH-1:0]            cnt;
    logic [DUTY_WIDTH-1:0]            cnt_nxt;
    logic                             cnt_up;
    logic                             cnt_up_nxt;
    logic                             at_zero;
    logic [NUM_PHASES*DUTY_WIDTH-1:0] shd_duty;
    logic [NUM_PHASES*DUTY_WIDTH-1:0] act_duty;
    logic [NUM_PHASES-1:0]            shd_hz;
    logic [NUM_PHASES-1:0]            act_hz;
    logic [1:0]                       tgt        [NUM_PHASES];
    logic [1:0]                       tgt_q      [NUM_PHASES];
    logic [DT_W-1:0]                  stable_q   [NUM_PHASES];
    logic [DT_W-1:0]                  stable_nxt [NUM_PHASES];

    function automatic logic [1:0] target_of(input logic hz,
                                             input logic [DUTY_WIDTH-1:0] d,
                                             input logic [DUTY_WIDTH-1:0] c);
        if (hz)
            return TGT_OFF;
        else if ((d == MAX_COUNT) || ((d != '0) && (c < d)))
            return TGT_HIGH;
        else
            return TGT_LOW;
    endfunction

    assign at_zero = (cnt == '0);

    // Carrier: sawtooth wraps naturally; triangle turns at MAX_COUNT and at 0.
    always_comb begin
        cnt_nxt    = cnt + DUTY_WIDTH'(1);
        cnt_up_nxt = cnt_up;
        if (CENTER_ALIGNED != 0) begin
            if (cnt_up) begin
                if (cnt == MAX_COUNT) begin
                    cnt_nxt    = cnt - DUTY_WIDTH'(1);
                    cnt_up_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt - DUTY_WIDTH'(1);
                if (cnt == DUTY_WIDTH'(1))
                    cnt_up_nxt = 1'b1;
            end
        end
    end

    // Target per phase and its dead-time stability counter.
    always_comb begin
        for (int p = 0; p < NUM_PHASES; p++) begin
            tgt[p] = target_of(act_hz[p], act_duty[p*DUTY_WIDTH +: DUTY_WIDTH], cnt);
            if (tgt[p] != tgt_q[p])
                stable_nxt[p] = '0;
            else if (stable_q[p] != DT)
                stable_nxt[p] = stable_q[p] + DT_W'(1);
            else
                stable_nxt[p] = stable_q[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            cnt_up       <= 1'b1;
            shd_duty     <= '0;
            act_duty     <= '0;
            shd_hz       <= '1;
            act_hz       <= '1;
            period_start <= 1'b0;
            pwm_high     <= '0;
            pwm_low      <= '0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                tgt_q[p]    <= TGT_OFF;
                stable_q[p] <= '0;
            end
        end else begin
            cnt          <= cnt_nxt;
            cnt_up       <= cnt_up_nxt;
            period_start <= at_zero;
            if (load) begin
                shd_duty <= duty_cycle;
                shd_hz   <= high_z;
            end
            // A load coinciding with the period boundary bypasses the shadow stage.
            if (at_zero) begin
                act_duty <= load ? duty_cycle : shd_duty;
                act_hz   <= load ? high_z : shd_hz;
            end
            for (int p = 0; p < NUM_PHASES; p++) begin
                tgt_q[p]    <= tgt[p];
                stable_q[p] <= stable_nxt[p];
                pwm_high[p] <= (tgt[p] == TGT_HIGH) && (stable_nxt[p] == DT);
                pwm_low[p]  <= (tgt[p] == TGT_LOW) && (stable_nxt[p] == DT);
            end
        end
    end

endmodule

// File: tb/tb_bldc_pwm_bank.sv
// Directed bench for bldc_pwm_bank: an edge-aligned and a center-aligned instance
// (DUTY_WIDTH=4, DEAD_TIME=2, 3 phases) share stimulus; waveforms are captured per period.
module tb_bldc_pwm_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] duty;
    logic [2:0]  hz;
    logic        load;
    logic [2:0]  ph_e, pl_e, ph_c, pl_c;
    logic        ps_e, ps_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bldc_pwm_bank #(.NUM_PHASES(3), .DUTY_WIDTH(4), .DEAD_TIME(2), .CENTER_ALIGNED(0)) dut_e (
        .clk(clk), .rst(rst), .duty_cycle(duty), .high_z(hz), .load(load),
        .pwm_high(ph_e), .pwm_low(pl_e), .period_start(ps_e));

    bldc_pwm_bank #(.NUM_PHASES(3), .DUTY_WIDTH(4), .DEAD_TIME(2), .CENTER_ALIGNED(1)) dut_c (
        .clk(clk), .rst(rst), .duty_cycle(duty), .high_z(hz), .load(load),
        .pwm_high(ph_c), .pwm_low(pl_c), .period_start(ps_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input bit ctr, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            seen = ctr ? ps_c : ps_e;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s period_start wait: got=0 exp=1 within 64 cycles", tag);
        end
    endtask

    task automatic do_load(input logic [11:0] d, input logic [2:0] h);
        duty = d;
        hz   = h;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Records n samples starting with the current one; bit i of each vector is sample i.
    task automatic cap(input bit ctr, input int n, input int load_at,
                       input logic [11:0] ld_duty, input logic [2:0] ld_hz,
                       output logic [2:0][31:0] hi, output logic [2:0][31:0] lo,
                       output logic [31:0] psv, output logic ovl);
        hi  = '0;
        lo  = '0;
        psv = '0;
        ovl = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            if (i == load_at + 1) load = 1'b0;
            for (int p = 0; p < 3; p++) begin
                hi[p][i] = ctr ? ph_c[p] : ph_e[p];
                lo[p][i] = ctr ? pl_c[p] : pl_e[p];
            end
            psv[i] = ctr ? ps_c : ps_e;
            if (ctr ? |(ph_c & pl_c) : |(ph_e & pl_e)) ovl = 1'b1;
            if (i == load_at) begin
                duty = ld_duty;
                hz   = ld_hz;
                load = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [47:0] pse, psc;
        logic [5:0]  outs;
        rst = 1'b1; load = 1'b0; duty = '0; hz = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ph_e, pl_e, ps_e} !== 7'b0) begin
            bad++; $display("FAIL reset_edge_outs got=%b exp=0000000", {ph_e, pl_e, ps_e});
        end
        total++;
        if ({ph_c, pl_c, ps_c} !== 7'b0) begin
            bad++; $display("FAIL reset_ctr_outs got=%b exp=0000000", {ph_c, pl_c, ps_c});
        end
        rst  = 1'b0;
        pse  = '0;
        psc  = '0;
        outs = '0;
        for (int i = 0; i < 48; i++) begin
            tick();
            pse[i] = ps_e;
            psc[i] = ps_c;
            outs   = outs | {ph_e, pl_e};
        end
        total++;
        if (pse !== 48'h0001_0001_0001) begin
            bad++; $display("FAIL reset_ps_edge got=%h exp=000100010001", pse);
        end
        total++;
        if (psc !== 48'h0000_4000_0001) begin
            bad++; $display("FAIL reset_ps_ctr got=%h exp=000040000001", psc);
        end
        total++;
        if (outs !== 6'b0) begin
            bad++; $display("FAIL reset_idle_outs got=%b exp=000000", outs);
        end
    endtask

    task automatic test_edge_duty8();
        logic [2:0][31:0] hi, lo;
        logic [31:0] psv;
        logic ovl;
        wait_ps(1'b0, "duty8");
        do_load(12'h008, 3'b110);
        wait_ps(1'b0, "duty8");
        wait_ps(1'b0, "duty8");
        cap(1'b0, 16, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if (hi[0] !== 32'h0000_00FC) begin
            bad++; $display("FAIL duty8_high got=%h exp=000000fc", hi[0]);
        end
        total++;
        if (lo[0] !== 32'h0000_FC00) begin
            bad++; $display("FAIL duty8_low got=%h exp=0000fc00", lo[0]);
        end
        total++;
        if ((hi[1] | lo[1] | hi[2] | lo[2]) !== 32'h0) begin
            bad++; $display("FAIL duty8_float_phases got=%h exp=0", hi[1] | lo[1] | hi[2] | lo[2]);
        end
        total++;
        if (psv !== 32'h1) begin
            bad++; $display("FAIL duty8_period got=%h exp=00000001", psv);
        end
        total++;
        if (ovl !== 1'b0) begin
            bad++; $display("FAIL duty8_overlap got=%b exp=0", ovl);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            tick();
            seen = ph_e[0];
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL midreset_precond pwm_high0 got=0 exp=1");
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ph_e, pl_e, ps_e} !== 7'b0) begin
            bad++; $display("FAIL midreset_edge got=%b exp=0000000", {ph_e, pl_e, ps_e});
        end
        total++;
        if ({ph_c, pl_c, ps_c} !== 7'b0) begin
            bad++; $display("FAIL midreset_ctr got=%b exp=0000000", {ph_c, pl_c, ps_c});
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({ps_e, ps_c} !== 2'b11) begin
            bad++; $display("FAIL midreset_restart got=%b exp=11", {ps_e, ps_c});
        end
    endtask

    task automatic test_rails();
        logic [2:0][31:0] hi, lo;
        logic [31:0] psv;
        logic ovl;
        wait_ps(1'b0, "rails");
        do_load(12'h1F0, 3'b000);
        wait_ps(1'b0, "rails");
        wait_ps(1'b0, "rails");
        cap(1'b0, 16, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if ({hi[0], lo[0]} !== {32'h0, 32'h0000_FFFF}) begin
            bad++; $display("FAIL rail_duty0 got=%h/%h exp=00000000/0000ffff", hi[0], lo[0]);
        end
        total++;
        if ({hi[1], lo[1]} !== {32'h0000_FFFF, 32'h0}) begin
            bad++; $display("FAIL rail_duty15 got=%h/%h exp=0000ffff/00000000", hi[1], lo[1]);
        end
        total++;
        if ({hi[2], lo[2]} !== {32'h0, 32'h0000_FFF8}) begin
            bad++; $display("FAIL swallow_duty1 got=%h/%h exp=00000000/0000fff8", hi[2], lo[2]);
        end
        total++;
        if (ovl !== 1'b0) begin
            bad++; $display("FAIL rails_overlap got=%b exp=0", ovl);
        end
    endtask

    task automatic test_double_buffer();
        logic [2:0][31:0] hi, lo;
        logic [31:0] psv;
        logic ovl;
        wait_ps(1'b0, "dbuf");
        do_load(12'h1F4, 3'b110);
        wait_ps(1'b0, "dbuf");
        wait_ps(1'b0, "dbuf");
        cap(1'b0, 16, 4, 12'h1FC, 3'b110, hi, lo, psv, ovl);
        total++;
        if ({hi[0], lo[0]} !== {32'h0000_000C, 32'h0000_FFC0}) begin
            bad++; $display("FAIL dbuf_current got=%h/%h exp=0000000c/0000ffc0", hi[0], lo[0]);
        end
        tick();
        cap(1'b0, 16, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if ({hi[0], lo[0]} !== {32'h0000_0FFC, 32'h0000_C000}) begin
            bad++; $display("FAIL dbuf_next got=%h/%h exp=00000ffc/0000c000", hi[0], lo[0]);
        end
        total++;
        if (psv !== 32'h1) begin
            bad++; $display("FAIL dbuf_period got=%h exp=00000001", psv);
        end
    endtask

    task automatic test_high_z();
        logic [2:0][31:0] hi, lo;
        logic [31:0] psv;
        logic ovl;
        wait_ps(1'b0, "highz");
        do_load(12'h18C, 3'b100);
        wait_ps(1'b0, "highz");
        wait_ps(1'b0, "highz");
        do_load(12'h18C, 3'b110);
        wait_ps(1'b0, "highz");
        cap(1'b0, 16, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if ((hi[1] | lo[1]) !== 32'h0) begin
            bad++; $display("FAIL highz_float got=%h/%h exp=00000000/00000000", hi[1], lo[1]);
        end
        total++;
        if ({hi[0], lo[0]} !== {32'h0000_0FFC, 32'h0000_C000}) begin
            bad++; $display("FAIL highz_neighbour got=%h/%h exp=00000ffc/0000c000", hi[0], lo[0]);
        end
        // Load lands on the counter==0 cycle, so it goes straight to the active set.
        duty = 12'h18C;
        hz   = 3'b100;
        load = 1'b1;
        tick();
        load = 1'b0;
        cap(1'b0, 16, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if ({hi[1], lo[1]} !== {32'h0000_00F8, 32'h0000_FC00}) begin
            bad++; $display("FAIL highz_resume got=%h/%h exp=000000f8/0000fc00", hi[1], lo[1]);
        end
        total++;
        if (psv !== 32'h1) begin
            bad++; $display("FAIL highz_period got=%h exp=00000001", psv);
        end
    endtask

    task automatic test_center();
        logic [2:0][31:0] hi, lo;
        logic [31:0] psv;
        logic ovl;
        wait_ps(1'b1, "center");
        do_load(12'h004, 3'b110);
        wait_ps(1'b1, "center");
        wait_ps(1'b1, "center");
        cap(1'b1, 30, -10, '0, '0, hi, lo, psv, ovl);
        total++;
        if (hi[0] !== 32'h2000_000F) begin
            bad++; $display("FAIL center_high got=%h exp=2000000f", hi[0]);
        end
        total++;
        if (lo[0] !== 32'h07FF_FFC0) begin
            bad++; $display("FAIL center_low got=%h exp=07ffffc0", lo[0]);
        end
        total++;
        if (psv !== 32'h1) begin
            bad++; $display("FAIL center_period got=%h exp=00000001", psv);
        end
        total++;
        if (ovl !== 1'b0) begin
            bad++; $display("FAIL center_overlap got=%b exp=0", ovl);
        end
    endtask

    initial begin
        test_reset();
        test_edge_duty8();
        test_reset_mid();
        test_rails();
        test_double_buffer();
        test_high_z();
        test_center();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
